// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add sequencer.
// Optional build macro: SERIAL_ADD_SUB_EN (adds a subtract mode to serial_add_ctrl).
package serial_add_pkg;

  // Operand width used when the instantiating module does not override it
  localparam int DEFAULT_WIDTH = 8;

  // Sequencer states: waiting for operands, shifting bits, holding the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width; it only has to reach WIDTH-1, and it never shrinks below one bit
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full-adder cell, shared by every bit position of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry of the three input bits
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: one full-adder cell processes the operands LSB first,
// one bit per clock, with the carry held in a flop between cycles.
// Optional build macro: SERIAL_ADD_SUB_EN adds a 'sub' input selecting op_a - op_b.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_cout;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // The single shared adder cell always sees the current low bits and the carry flop
  full_adder u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Operand B and initial carry as loaded on accept; subtraction adds ~B + 1
`ifdef SERIAL_ADD_SUB_EN
  always_comb begin
    b_load     = sub ? ~op_b : op_b;
    carry_load = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_load     = op_b;
    carry_load = cin;
  end
`endif

  // State register; reset returns the sequencer to IDLE and aborts any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; in_ready is held low while reset is applied
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: load operands on accept, then shift one bit per cycle through the cell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= op_a;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result is read straight from the sum shifter and carry flop; valid only in DONE
  always_comb begin
    sum  = s_sh;
    cout = carry;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard testbench for serial_add_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result handshake is presented.
module tb_serial_add_ctrl;

  localparam int W = 8;
  localparam logic [W-1:0] MASK = {W{1'b1}};

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  exp_t         sb[$];
  int           checks;
  int           errors;
  int           cycle;
  int           policy;
  logic         prev_ov;
  logic [W-1:0] held_sum;
  logic         held_cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: plain integer arithmetic on the operands
  function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic c, input logic s);
    exp_t e;
    longint unsigned t;
    if (s) begin
      t      = (longint'(a) - longint'(b)) & longint'(MASK);
      e.sum  = t[W-1:0];
      e.cout = (a >= b);
    end else begin
      t      = longint'(a) + longint'(b) + longint'(c);
      e.sum  = t[W-1:0];
      e.cout = t[W];
    end
    e.acc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  // Present one operation from a negedge and hold it until accepted
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input logic s);
    exp_t e;
    op_a     = a;
    op_b     = b;
    cin      = c;
`ifdef SERIAL_ADD_SUB_EN
    sub      = s;
`endif
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        e     = refModel(a, b, c, s);
        e.acc = cycle + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    errors++;
    $display("[TB] FAIL accept_timeout: in_ready never seen, got 0 expected 1");
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !out_valid) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
  endtask

  // Monitor: latency, stability while stalled, and scoreboard compare on handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov   = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (out_valid) begin
        checkOutput("in_ready_in_done", {63'd0, in_ready}, 64'd0);
        checkOutput("busy_in_done", {63'd0, busy}, 64'd1);
        if (!prev_ov) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_result: got out_valid=1 expected no pending op");
          end else begin
            checkOutput("latency", 64'(cycle - sb[0].acc), 64'(W));
          end
          held_sum  = sum;
          held_cout = cout;
        end else begin
          checkOutput("stall_sum_stable", {56'd0, sum}, {56'd0, held_sum});
          checkOutput("stall_cout_stable", {63'd0, cout}, {63'd0, held_cout});
        end
      end
      prev_ov = out_valid;
      case (policy)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(3) != 0);
        default: out_ready = 1'b0;
      endcase
      if (out_valid && out_ready && sb.size() > 0) begin
        checkOutput("sum", {56'd0, sum}, {56'd0, sb[0].sum});
        checkOutput("cout", {63'd0, cout}, {63'd0, sb[0].cout});
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    cycle    = 0;
    policy   = 0;
    prev_ov  = 1'b0;
    in_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    cin      = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub      = 1'b0;
`endif
    out_ready = 1'b0;
    rst_n    = 1'b0;
    #12;
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_sum", {56'd0, sum}, 64'd0);
    checkOutput("rst_cout", {63'd0, cout}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", {63'd0, in_ready}, 64'd1);

    $display("[TB] directed additions");
    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    waitDrain();
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    waitDrain();
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] stall in DONE");
    policy = 2;
    applyStimulus(8'h33, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    checkOutput("stall_reached_done", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      op_a     = W'($urandom);
      op_b     = W'($urandom);
      cin      = 1'($urandom);
      @(negedge clk);
      checkOutput("stall_out_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    policy   = 0;
    for (int i = 0; i < 5 && out_valid; i++) @(negedge clk);
    checkOutput("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
    waitDrain();

    $display("[TB] reset during RUN");
    applyStimulus(8'h77, 8'h19, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("abort_sum", {56'd0, sum}, 64'd0);
    checkOutput("abort_cout", {63'd0, cout}, 64'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", {63'd0, in_ready}, 64'd1);
    applyStimulus(8'h01, 8'h02, 1'b0, 1'b0);
    waitDrain();

`ifdef SERIAL_ADD_SUB_EN
    $display("[TB] subtraction");
    applyStimulus(8'h10, 8'h01, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(8'h00, 8'h01, 1'b1, 1'b1);
    waitDrain();
`endif

    $display("[TB] random back-to-back operations");
    policy = 1;
    for (int n = 0; n < 1000; n++) begin
`ifdef SERIAL_ADD_SUB_EN
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif
    end
    policy = 0;
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial add sequencer. It accepts WIDTH-bit operand pairs over a valid/ready handshake and drives one 1-bit full-adder cell, LSB first, for WIDTH cycles. The carry is kept in a flop between cycles. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. This is the area-minimal adder for narrow control paths, where one full-adder cell is shared across all bit positions.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
op_a  input  WIDTH  operand A, sampled only on accept
op_b  input  WIDTH  operand B, sampled only on accept
cin  input  1  initial carry-in, sampled only on accept
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result bits
cout  output  1  final carry-out
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all shift registers, carry flop and bit counter = 0.
  - sum=0, cout=0, out_valid=0, busy=0.
  - in_ready is forced 0 while rst_n is low.
- FSM states IDLE, RUN, DONE; encoded as an enum in the package.
- IDLE:
  - in_ready=1.
  - Accept on a rising edge with in_valid&&in_ready: a_sh<=op_a, b_sh<=op_b, carry<=cin, cnt<=0, state<=RUN.
- RUN:
  - in_ready=0.
  - Cell inputs: a=a_sh[0], b=b_sh[0], cin=carry.
  - Each edge: s_sh<={S, s_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1 with zero fill; carry<=Cout; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: state<=DONE.
- DONE:
  - out_valid=1; sum=s_sh; cout=carry.
  - Held stable until out_valid&&out_ready is seen on an edge, then state<=IDLE.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge.
- Throughput: at best one operation per WIDTH+2 cycles. in_ready never rises in the same cycle as the output handshake; the FSM always passes through IDLE.
- Operand inputs are don't-care outside the accept edge. in_valid while in RUN/DONE is ignored and nothing is queued.
- sum/cout keep their last values after leaving DONE. They are guaranteed only while out_valid=1.
- Arithmetic is modulo 2^WIDTH, with cout = bit WIDTH of op_a+op_b+cin.
- cnt width is $clog2(WIDTH). Wrap from WIDTH-1 is never reached, because the exit to DONE occurs first.
- rst_n asserted mid-RUN or in DONE aborts the operation: no out_valid pulse, result discarded, IDLE after release.
- out_ready is ignored outside DONE.

Optional Feature:
SERIAL_ADD_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled on accept.
  - When sub=1: b_sh loads ~op_b and carry loads 1, ignoring cin. Result = op_a-op_b modulo 2^WIDTH; cout=1 means no borrow.
- Undefined: port absent; pure addition.

Decomposition:
- Package serial_add_pkg holds:
  - state enum typedef (IDLE, RUN, DONE);
  - localparam for the default WIDTH;
  - a function computing the counter width.
- Sub-module: the existing full_adder bit cell, instantiated once. The controller contains no adder logic of its own.

Test Plan:
- WIDTH=8, op_a=0x5A, op_b=0x3C, cin=0 -> sum=0x96, cout=0; out_valid exactly 8 cycles after accept.
- op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1. Then op_a=0x00, op_b=0x00, cin=1 -> sum=0x01, cout=0.
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> sum/cout/out_valid stable, in_ready=0, new op not taken. The next op is accepted only after the handshake plus one IDLE cycle.
- Assert rst_n=0 three cycles into RUN -> all outputs 0 immediately, no out_valid. After release: in_ready=1, and a fresh 0x01+0x02 gives 0x03.
- Random back-to-back operations (1000 ops) against a reference model a+b+cin; all sums and carries match, and every latency = WIDTH.
- With SERIAL_ADD_SUB_EN, sub=1: 0x10-0x01 -> sum=0x0F, cout=1; 0x00-0x01 -> sum=0xFF, cout=0.
